// File: rtl/opcode_buffer.sv
// ---------------------------------------------------------------------------
// opcode_buffer
//
// Instruction-fetch front end. On request it reads four consecutive bytes
// from a byte-wide memory port, starting at ip, and delivers them as one
// 32-bit opcode.
//
// Handshake: the opcode is valid in the single cycle where busy is low.
// There is no back-pressure; the consumer must take opcode in that cycle
// and may change ip on the edge that ends it. ip and start_loading are only
// looked at while the block is idle (LOAD).
//
// Memory side: mem_request is a one-cycle strobe with mem_addr valid. The
// memory answers with mem_busy low and mem_data valid in some later cycle;
// mem_addr is held stable until then.
//
// Build option:
//   OPCODE_BUFFER_LITTLE_ENDIAN_EN - when defined, the byte at ip+0 lands in
//   opcode[7:0]; otherwise (default) it lands in opcode[31:24]. Timing is
//   the same either way.
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   asynchronous, active-high reset
//   ip            in   address of first opcode byte
//   start_loading in   fetch enable
//   mem_data      in   memory read data
//   mem_busy      in   memory read still in progress
//   busy          out  low for one cycle when opcode is valid
//   opcode        out  assembled instruction word, held between deliveries
//   mem_addr      out  byte address to memory
//   mem_request   out  one-cycle read strobe
//   dbgState      out  current FSM state (0 LOAD, 1 REQ, 2 WAIT, 3 DONE)
// ---------------------------------------------------------------------------
module opcode_buffer #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] ip,
    input  logic                  start_loading,
    input  logic [7:0]            mem_data,
    input  logic                  mem_busy,
    output logic                  busy,
    output logic [31:0]           opcode,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_request,
    output logic [1:0]            dbgState
);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] base;
    logic [1:0]            byteIdx;
    logic [1:0]            nextIdx;
    // First three bytes, kept aside so opcode never shows a partial word.
    logic [23:0]           stage;
    logic [31:0]           assembled;

    assign nextIdx  = byteIdx + 2'd1;
    assign dbgState = state;

    // Final word built from the staged bytes plus the byte arriving now.
`ifdef OPCODE_BUFFER_LITTLE_ENDIAN_EN
    assign assembled = {mem_data, stage[7:0], stage[15:8], stage[23:16]};
`else
    assign assembled = {stage[23:16], stage[15:8], stage[7:0], mem_data};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_LOAD;
            busy        <= 1'b1;
            opcode      <= 32'd0;
            mem_addr    <= '0;
            mem_request <= 1'b0;
            byteIdx     <= 2'd0;
            base        <= '0;
            stage       <= 24'd0;
        end else begin
            case (state)
                S_LOAD: begin
                    busy        <= 1'b1;
                    mem_request <= 1'b0;
                    if (start_loading) begin
                        base        <= ip;
                        byteIdx     <= 2'd0;
                        mem_addr    <= ip;
                        mem_request <= 1'b1;
                        state       <= S_REQ;
                    end
                end

                S_REQ: begin
                    // Strobe lasts exactly one cycle; address stays put.
                    mem_request <= 1'b0;
                    state       <= S_WAIT;
                end

                S_WAIT: begin
                    if (!mem_busy) begin
                        case (byteIdx)
                            2'd0: stage[23:16] <= mem_data;
                            2'd1: stage[15:8]  <= mem_data;
                            2'd2: stage[7:0]   <= mem_data;
                            default: begin
                                opcode <= assembled;
                                busy   <= 1'b0;
                            end
                        endcase
                        if (byteIdx == 2'd3) begin
                            state <= S_DONE;
                        end else begin
                            byteIdx     <= nextIdx;
                            // Address arithmetic wraps modulo 2^ADDR_WIDTH.
                            mem_addr    <= base + {{(ADDR_WIDTH-2){1'b0}}, nextIdx};
                            mem_request <= 1'b1;
                            state       <= S_REQ;
                        end
                    end
                end

                S_DONE: begin
                    busy  <= 1'b1;
                    state <= S_LOAD;
                end

                default: begin
                    state <= S_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_opcode_buffer.sv
// ---------------------------------------------------------------------------
// tb_opcode_buffer
//
// Driver tasks issue fetches and push the expected request addresses,
// memory wait counts, opcode and delivery cycle into queues. A memory
// responder serves requests from a fixed byte image, and a monitor pops and
// compares whenever the block strobes a request or delivers an opcode.
// ---------------------------------------------------------------------------
module tb_opcode_buffer;

    logic        clk;
    logic        reset;
    logic [31:0] ip;
    logic        start_loading;
    logic [7:0]  mem_data;
    logic        mem_busy;
    logic        busy;
    logic [31:0] opcode;
    logic [31:0] mem_addr;
    logic        mem_request;
    logic [1:0]  dbgState;

    opcode_buffer #(.ADDR_WIDTH(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .ip            (ip),
        .start_loading (start_loading),
        .mem_data      (mem_data),
        .mem_busy      (mem_busy),
        .busy          (busy),
        .opcode        (opcode),
        .mem_addr      (mem_addr),
        .mem_request   (mem_request),
        .dbgState      (dbgState)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [31:0] addrQ[$];
    logic [31:0] opQ[$];
    int          doneQ[$];
    int          waitQ[$];
    logic [31:0] heldOp = 32'd0;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Memory image: a few fixed bytes at the bottom, a scrambled pattern elsewhere.
    function automatic logic [7:0] memByte(input logic [31:0] a);
        case (a)
            32'd0:   return 8'h20;
            32'd1:   return 8'h01;
            32'd2:   return 8'h00;
            32'd3:   return 8'h05;
            32'd4:   return 8'h11;
            32'd5:   return 8'h22;
            32'd6:   return 8'h33;
            32'd7:   return 8'h44;
            default: return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'hA5;
        endcase
    endfunction

    // Reference model: the opcode is the four bytes at ip..ip+3 (wrapping),
    // delivered 8 edges after the sampling edge plus one per wait cycle.
    task automatic pushExpect(input logic [31:0] ipVal, input logic [7:0] waits, input int startC);
        logic [7:0] b [4];
        int tot;
        tot = 0;
        for (int k = 0; k < 4; k++) begin
            addrQ.push_back(ipVal + 32'(k));
            waitQ.push_back(int'(waits[2*k +: 2]));
            b[k] = memByte(ipVal + 32'(k));
            tot += int'(waits[2*k +: 2]);
        end
`ifdef OPCODE_BUFFER_LITTLE_ENDIAN_EN
        opQ.push_back({b[3], b[2], b[1], b[0]});
`else
        opQ.push_back({b[0], b[1], b[2], b[3]});
`endif
        doneQ.push_back(startC + 8 + tot);
    endtask

    // ---------------- driver tasks ----------------
    task automatic startFetch(input logic [31:0] ipVal, input logic [7:0] waits, input logic hold);
        @(negedge clk);
        ip = ipVal;
        start_loading = 1'b1;
        pushExpect(ipVal, waits, cyc + 1);
        @(negedge clk);
        start_loading = hold;
    endtask

    task automatic waitDone();
        int n;
        n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL doneTimeout actual=busy_%b expected=busy_0", busy);
        end
    endtask

    task automatic checkReset();
        check("rstBusy", {31'd0, busy}, 32'd1);
        check("rstOpcode", opcode, 32'd0);
        check("rstReq", {31'd0, mem_request}, 32'd0);
        check("rstAddr", mem_addr, 32'd0);
    endtask

    task automatic applyReset();
        @(posedge clk);
        #2 reset = 1'b1;
        addrQ.delete();
        opQ.delete();
        doneQ.delete();
        waitQ.delete();
        heldOp = 32'd0;
        #1 checkReset();
        @(posedge clk);
        #2 reset = 1'b0;
    endtask

    // ---------------- memory responder ----------------
    logic [31:0] pendAddr = 32'd0;
    logic        pending = 1'b0;
    int          waitsLeft = 0;

    always @(negedge clk) begin
        if (reset) begin
            pending  = 1'b0;
            mem_busy = 1'b0;
        end else if (pending) begin
            check("addrHeld", mem_addr, pendAddr);
            check("noExtraReq", {31'd0, mem_request}, 32'd0);
            if (waitsLeft > 0) begin
                mem_busy = 1'b1;
                mem_data = 8'($urandom);
                waitsLeft--;
            end else begin
                mem_busy = 1'b0;
                mem_data = memByte(pendAddr);
                pending  = 1'b0;
            end
        end else if (mem_request === 1'b1) begin
            pendAddr  = mem_addr;
            pending   = 1'b1;
            waitsLeft = (waitQ.size() > 0) ? waitQ.pop_front() : 0;
            mem_busy  = 1'b0;
            mem_data  = 8'($urandom);
        end
    end

    // ---------------- monitor ----------------
    logic [31:0] expOp;
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_request === 1'b1) begin
                if (addrQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpectedReq actual=%h expected=none", mem_addr);
                end else begin
                    check("reqAddr", mem_addr, addrQ.pop_front());
                end
            end
            if (busy === 1'b0) begin
                if (opQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpectedDone actual=%h expected=none", opcode);
                end else begin
                    expOp = opQ.pop_front();
                    check("opcode", opcode, expOp);
                    check("doneCycle", 32'(cyc), 32'(doneQ.pop_front()));
                    heldOp = expOp;
                end
            end else begin
                check("opcodeHeld", opcode, heldOp);
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        reset         = 1'b0;
        ip            = 32'd0;
        start_loading = 1'b0;
        mem_data      = 8'd0;
        mem_busy      = 1'b0;

        #2 reset = 1'b1;
        #1 checkReset();
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;

        // Basic zero-wait fetch from address 0.
        startFetch(32'd0, 8'h00, 1'b0);
        waitDone();

        // Three wait cycles on byte 2.
        startFetch(32'd0, {2'd0, 2'd3, 2'd0, 2'd0}, 1'b0);
        waitDone();

        // Back-to-back with start_loading held; consumer moves ip on DONE.
        startFetch(32'd0, 8'h00, 1'b1);
        waitDone();
        ip = 32'd4;
        pushExpect(32'd4, 8'h00, cyc + 2);
        @(negedge clk);
        @(negedge clk);
        start_loading = 1'b0;
        waitDone();

        // Address wrap past all-ones.
        startFetch(32'hFFFF_FFFE, 8'h00, 1'b0);
        waitDone();

        // Randomized addresses and wait patterns.
        for (int i = 0; i < 10; i++) begin
            startFetch($urandom, 8'($urandom_range(0, 255)), 1'b0);
            waitDone();
        end

        // Abort after two bytes, then a clean fetch from the same address.
        startFetch(32'h10, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        applyReset();
        repeat (3) @(negedge clk);
        startFetch(32'h10, 8'h00, 1'b0);
        waitDone();

        repeat (5) @(negedge clk);
        check("addrQEmpty", 32'(addrQ.size()), 32'd0);
        check("opQEmpty", 32'(opQ.size()), 32'd0);
        check("doneQEmpty", 32'(doneQ.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
